// File: rtl/regfile_pkg.sv
// Shared sizes and types for the register-file writeback scheduler.
package regfile_pkg;

  localparam int DATA_W    = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  localparam int RF_ADDR_W = 6;

  // Which requester received the most recent grant.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } arb_state_e;

  // Register-file write address: architectural index with the MSB tied low.
  function automatic logic [RF_ADDR_W-1:0] rf_addr(input logic [REG_IDX_W-1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the ALU and load writeback requesters.
// Grants are combinational; the state only moves when a grant is issued.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       gnt_alu;
  logic       gnt_mem;

  // Grant the prioritised requester on conflict, otherwise whoever asks.
  always_comb begin
    gnt_alu = req_alu_i & (~req_mem_i | (state_q == LAST_MEM));
    gnt_mem = req_mem_i & (~req_alu_i | (state_q == LAST_ALU));
    state_d = state_q;
    if (gnt_alu) begin
      state_d = LAST_ALU;
    end else if (gnt_mem) begin
      state_d = LAST_MEM;
    end
  end

  assign gnt_alu_o = gnt_alu;
  assign gnt_mem_o = gnt_mem;

  // Arbiter state; reset leaves the ALU in front for the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LAST_MEM;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file writeback scheduler: arbitrates the single write port between
// the ALU and load paths, registers the write, and keeps a pending-write
// scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREG   = regfile_pkg::NREG
) (
  input  logic                                Clk,
  input  logic                                Rst_n,
  input  logic                                IssueValid,
  input  logic [regfile_pkg::REG_IDX_W-1:0]   IssueRs1,
  input  logic [regfile_pkg::REG_IDX_W-1:0]   IssueRs2,
  input  logic [regfile_pkg::REG_IDX_W-1:0]   IssueRd,
  output logic                                Stall,
  input  logic                                AluValid,
  input  logic [regfile_pkg::REG_IDX_W-1:0]   AluRd,
  input  logic [DATA_W-1:0]                   AluData,
  output logic                                AluReady,
  input  logic                                MemValid,
  input  logic [regfile_pkg::REG_IDX_W-1:0]   MemRd,
  input  logic [DATA_W-1:0]                   MemData,
  output logic                                MemReady,
  output logic [regfile_pkg::RF_ADDR_W-1:0]   A3,
  output logic [DATA_W-1:0]                   WriteData,
  output logic                                WE,
  output logic [NREG-1:0]                     Pending
);

  import regfile_pkg::*;

  localparam int IDX_SPACE = 2 ** REG_IDX_W;

  // Raw grants feed internal state; reset gating is applied only at the ports
  // so no flop input depends on the asynchronous reset net.
  logic gnt_alu;
  logic gnt_mem;

  rr_arb2 u_arb (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .req_alu_i (AluValid),
    .req_mem_i (MemValid),
    .gnt_alu_o (gnt_alu),
    .gnt_mem_o (gnt_mem)
  );

  assign AluReady = Rst_n & gnt_alu;
  assign MemReady = Rst_n & gnt_mem;

  // Selected writeback request (a grant implies the matching Valid).
  logic                 wb_xfer;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [DATA_W-1:0]    wb_data;

  // Mux the granted requester onto the write path.
  always_comb begin
    wb_xfer = gnt_alu | gnt_mem;
    wb_rd   = gnt_alu ? AluRd   : MemRd;
    wb_data = gnt_alu ? AluData : MemData;
  end

  // Scoreboard state.
  logic [NREG-1:0]      pending_q;
  logic [NREG-1:0]      pending_d;
  logic [IDX_SPACE-1:0] pend_ext;
  logic [NREG-1:0]      set_hit;
  logic [NREG-1:0]      clr_hit;
  logic                 hazard;
  logic                 stall_raw;
  logic                 issue_fire;

  // Full index-space view of the scoreboard; x0 and unimplemented registers
  // read as never pending.
  generate
    for (genvar gi = 0; gi < IDX_SPACE; gi++) begin : g_pend_ext
      if (gi != 0 && gi < NREG) begin : g_live
        assign pend_ext[gi] = pending_q[gi];
      end else begin : g_zero
        assign pend_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Hazard check uses the registered scoreboard only: a clear happening this
  // cycle does not release the stall until the next cycle.
  always_comb begin
    hazard     = pend_ext[IssueRs1] | pend_ext[IssueRs2] | pend_ext[IssueRd];
    stall_raw  = IssueValid & hazard;
    issue_fire = IssueValid & ~stall_raw & (IssueRd != '0);
  end

  assign Stall = Rst_n & stall_raw;

  // Per-register next state: a new issue to the same register wins over the
  // writeback clear, so the bit ends set.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend_bit
      if (gi == 0) begin : g_x0
        assign set_hit[gi]   = 1'b0;
        assign clr_hit[gi]   = 1'b0;
        assign pending_d[gi] = 1'b0;
      end else begin : g_reg
        assign set_hit[gi]   = issue_fire & (IssueRd == REG_IDX_W'(gi));
        assign clr_hit[gi]   = wb_xfer & (wb_rd == REG_IDX_W'(gi));
        assign pending_d[gi] = set_hit[gi] ? 1'b1 :
                               (clr_hit[gi] ? 1'b0 : pending_q[gi]);
      end
    end
  endgenerate

  // Scoreboard register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign Pending = pending_q;

  // Registered write port.
  logic [RF_ADDR_W-1:0] a3_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 we_q;

  // Capture the transfer one cycle ahead of the write; x0 writes are
  // accepted but never enabled, and idle cycles keep address/data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      we_q    <= 1'b0;
      a3_q    <= '0;
      wdata_q <= '0;
    end else if (wb_xfer) begin
      we_q    <= (wb_rd != '0);
      a3_q    <= rf_addr(wb_rd);
      wdata_q <= wb_data;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign A3        = a3_q;
  assign WriteData = wdata_q;
  assign WE        = we_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a scoreboard of expected writes
// and a small reference model of the arbiter and pending bits.
module tb_regfile_wb_sched;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        IssueValid;
  logic [4:0]  IssueRs1, IssueRs2, IssueRd;
  logic        Stall;
  logic        AluValid;
  logic [4:0]  AluRd;
  logic [31:0] AluData;
  logic        AluReady;
  logic        MemValid;
  logic [4:0]  MemRd;
  logic [31:0] MemData;
  logic        MemReady;
  logic [5:0]  A3;
  logic [31:0] WriteData;
  logic        WE;
  logic [31:0] Pending;

  always #5 Clk = ~Clk;

  regfile_wb_sched #(.DATA_W(32), .NREG(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IssueValid(IssueValid), .IssueRs1(IssueRs1), .IssueRs2(IssueRs2), .IssueRd(IssueRd),
    .Stall(Stall),
    .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
    .A3(A3), .WriteData(WriteData), .WE(WE), .Pending(Pending)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [31:0] m_pend, m_pend_next;
  logic        m_last_mem, m_last_mem_next;
  logic        m_ga, m_gm, m_push;
  logic [31:0] saved_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend     = '0;
    m_last_mem = 1'b1;
    exp_q.delete();
  endtask

  // Before the edge: check combinational outputs against the model and
  // predict what the edge will do.
  task automatic pre_edge();
    logic stall_e;
    wr_t  w;
    #1;
    m_ga    = AluValid & (~MemValid | m_last_mem);
    m_gm    = MemValid & (~AluValid | ~m_last_mem);
    stall_e = IssueValid & (m_pend[IssueRs1] | m_pend[IssueRs2] | m_pend[IssueRd]);
    chk("alu_ready", AluReady, m_ga);
    chk("mem_ready", MemReady, m_gm);
    chk("stall", Stall, stall_e);
    m_pend_next     = m_pend;
    m_last_mem_next = m_last_mem;
    m_push          = 1'b0;
    if (m_ga || m_gm) begin
      w.rd   = m_ga ? AluRd : MemRd;
      w.data = m_ga ? AluData : MemData;
      m_pend_next[w.rd] = 1'b0;
      m_last_mem_next   = m_gm;
      if (w.rd != 5'd0) begin
        exp_q.push_back(w);
        m_push = 1'b1;
      end
    end
    if (IssueValid && !stall_e && IssueRd != 5'd0) m_pend_next[IssueRd] = 1'b1;
  endtask

  // After the edge: the registered write must match the scoreboard entry.
  task automatic post_edge();
    wr_t w;
    m_pend     = m_pend_next;
    m_last_mem = m_last_mem_next;
    if (m_push && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("we", WE, 1'b1);
      chk("a3", A3, {1'b0, w.rd});
      chk("wdata", WriteData, w.data);
    end else begin
      chk("we_idle", WE, 1'b0);
    end
    chk("pending", Pending, m_pend);
    if (m_ga) AluValid = 1'b0;
    if (m_gm) MemValid = 1'b0;
  endtask

  task automatic cycle();
    pre_edge();
    @(posedge Clk);
    #1;
    post_edge();
  endtask

  initial begin
    Rst_n = 1'b0;
    IssueValid = 0; IssueRs1 = 0; IssueRs2 = 0; IssueRd = 0;
    AluValid = 0; AluRd = 0; AluData = 0;
    MemValid = 0; MemRd = 0; MemData = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_we", WE, 1'b0);
    chk("rst_a3", A3, 6'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_pending", Pending, 32'd0);
    AluValid = 1; MemValid = 1; IssueValid = 1;
    #1;
    chk("rst_alu_ready", AluReady, 1'b0);
    chk("rst_mem_ready", MemReady, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    AluValid = 0; MemValid = 0; IssueValid = 0;
    Rst_n = 1'b1;

    // First conflict after reset: ALU then Mem
    AluValid = 1; AluRd = 5; AluData = 32'hAAAA0001;
    MemValid = 1; MemRd = 6; MemData = 32'hBBBB0002;
    cycle();
    chk("first_a3", A3, 6'd5);
    chk("first_wdata", WriteData, 32'hAAAA0001);
    cycle();
    chk("second_a3", A3, 6'd6);
    chk("second_wdata", WriteData, 32'hBBBB0002);
    cycle();

    // RAW stall and release
    IssueValid = 1; IssueRd = 7; IssueRs1 = 0; IssueRs2 = 0;
    cycle();
    chk("raw_pend7", Pending[7], 1'b1);
    IssueRs1 = 7; IssueRd = 8;
    #1;
    chk("raw_stall", Stall, 1'b1);
    cycle();
    AluValid = 1; AluRd = 7; AluData = 32'h0000_0077;
    #1;
    chk("raw_stall_xfer", Stall, 1'b1);
    cycle();
    #1;
    chk("raw_release", Stall, 1'b0);
    cycle();
    IssueValid = 0;
    cycle();

    // Writes to x0 and issue with x0 operands
    saved_pend = Pending;
    MemValid = 1; MemRd = 0; MemData = 32'hFFFFFFFF;
    #1;
    chk("x0_mem_ready", MemReady, 1'b1);
    cycle();
    chk("x0_we", WE, 1'b0);
    chk("x0_pending", Pending, saved_pend);
    IssueValid = 1; IssueRs1 = 0; IssueRs2 = 0; IssueRd = 0;
    #1;
    chk("x0_stall", Stall, 1'b0);
    cycle();
    IssueValid = 0;

    // Set and clear of the same register in one cycle
    IssueValid = 1; IssueRd = 9;
    AluValid = 1; AluRd = 9; AluData = 32'h0000_0099;
    cycle();
    chk("setclr_pend9", Pending[9], 1'b1);
    IssueValid = 0;
    MemValid = 1; MemRd = 8; MemData = 32'h0000_0088;
    cycle();

    // Sustained contention: grants alternate starting with the ALU
    for (int i = 0; i < 6; i++) begin
      if (!AluValid) begin
        AluValid = 1; AluRd = 5'(10 + i); AluData = $urandom;
      end
      if (!MemValid) begin
        MemValid = 1; MemRd = 5'(20 + i); MemData = $urandom;
      end
      #1;
      chk($sformatf("contend_alu_%0d", i), AluReady, (i % 2) == 0);
      chk($sformatf("contend_mem_%0d", i), MemReady, (i % 2) == 1);
      cycle();
    end
    cycle();
    cycle();

    // Reset in the cycle after a transfer
    IssueValid = 1; IssueRs1 = 0; IssueRs2 = 0; IssueRd = 20;
    cycle();
    IssueValid = 0;
    AluValid = 1; AluRd = 3; AluData = 32'h0000_0033;
    pre_edge();
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_we", WE, 1'b0);
    chk("midrst_pending", Pending, 32'd0);
    chk("midrst_a3", A3, 6'd0);
    MemValid = 1; MemRd = 4; MemData = 32'h0000_0044;
    IssueValid = 1; IssueRd = 20;
    #1;
    chk("midrst_alu_ready", AluReady, 1'b0);
    chk("midrst_mem_ready", MemReady, 1'b0);
    chk("midrst_stall", Stall, 1'b0);
    @(posedge Clk);
    #1;
    chk("midrst_we_hold", WE, 1'b0);
    IssueValid = 0;
    Rst_n = 1'b1;
    #1;
    chk("postrst_alu_wins", AluReady, 1'b1);
    cycle();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (x0..x31).
REQ-003 SHALL have port Clk, input, 1 bit, single clock; all state updates on posedge.
REQ-004 SHALL have port Rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port IssueValid, input, 1 bit, an instruction requests issue this cycle.
REQ-006 SHALL have ports IssueRs1, IssueRs2 and IssueRd, input, 5 bits each, source and destination register indices of the issuing instruction.
REQ-007 SHALL have port Stall, output, 1 bit, issue blocked by a hazard.
REQ-008 SHALL have ports AluValid (input, 1 bit), AluRd (input, 5 bits), AluData (input, DATA_W bits) and AluReady (output, 1 bit); together they form the ALU writeback requester.
REQ-009 SHALL have ports MemValid (input, 1 bit), MemRd (input, 5 bits), MemData (input, DATA_W bits) and MemReady (output, 1 bit); together they form the load writeback requester.
REQ-010 SHALL have port A3, output, 6 bits, register-file write address; MSB is always 0.
REQ-011 SHALL have port WriteData, output, DATA_W bits, register-file write data.
REQ-012 SHALL have port WE, output, 1 bit, register-file write enable.
REQ-013 SHALL have port Pending, output, NREG bits, scoreboard of registers with an outstanding write.

Function
REQ-014 SHALL arbitrate the single register-file write port between the ALU and Mem requesters with 2-way round-robin.
  - State LAST_ALU: Mem has priority.
  - State LAST_MEM: ALU has priority.
  - State transitions only on a grant.
REQ-015 SHALL drive AluReady/MemReady combinationally.
  - Ready = grant.
  - At most one Ready high per cycle.
  - Ready never high while the matching Valid is low.
REQ-016 SHALL treat Valid&Ready at a posedge as a transfer; requesters hold Rd/Data stable while Valid is high and Ready is low.
REQ-017 SHALL register A3/WriteData/WE from the granted request; WE is asserted exactly one cycle after the transfer (latency 1).
REQ-018 SHALL accept a write request with Rd==0 normally (Ready asserted) but keep WE=0, so x0 is never written.
REQ-019 SHALL hold WE=0 in any cycle following no transfer; A3/WriteData hold their previous values.
REQ-020 SHALL set Pending[IssueRd] at posedge when IssueValid & !Stall & IssueRd!=0.
REQ-021 SHALL clear Pending[Rd] at the posedge of a writeback transfer.
REQ-022 SHALL give set priority over clear when both target the same index in one cycle; the bit ends at 1.
REQ-023 SHALL compute Stall combinationally as IssueValid & (Pending[IssueRs1] | Pending[IssueRs2] | Pending[IssueRd]), covering RAW and WAW hazards.
REQ-024 SHALL treat Pending[0] as constant 0, so x0 never stalls.
REQ-025 SHALL NOT bypass a same-cycle clear into Stall; a stall caused by a register being written this cycle releases the following cycle.
REQ-026 SHALL NOT block writeback for an Rd whose Pending bit is 0; the write still occurs and the clear is a no-op.
REQ-027 SHALL keep Stall=0 whenever IssueValid=0.

Reset
REQ-028 SHALL, while Rst_n=0:
  - Force WE=0, A3=0, WriteData=0 and Pending=0.
  - Set the arbiter state to LAST_MEM, so ALU wins the first conflict.
REQ-029 SHALL, on reset asserted mid-operation, drop any registered write (WE=0 immediately) and discard all in-flight scoreboard state.
REQ-030 SHALL keep Ready outputs and Stall low while Rst_n=0.

Structure
REQ-031 SHALL take DATA_W, NREG, REG_IDX_W=5 and RF_ADDR_W=6 from shared package regfile_pkg, together with the arbiter-state enum {LAST_ALU, LAST_MEM}.
REQ-032 SHALL instantiate one sub-module, rr_arb2 (2-way round-robin arbiter with state register); the scoreboard and output register stay in regfile_wb_sched.

Verification
REQ-033 SHALL cover the first conflict after reset:
  - Stimulus: AluValid=1 (Rd=5, Data=0xAAAA0001) and MemValid=1 (Rd=6, Data=0xBBBB0002) on the first cycle after reset.
  - Required response: AluReady first, then WE=1 A3=5 WriteData=0xAAAA0001.
  - Next cycle: MemReady, then WE=1 A3=6 WriteData=0xBBBB0002.
REQ-034 SHALL cover a RAW stall and release:
  - Stimulus: issue Rd=7 with no stall; next cycle issue Rs1=7.
  - Required response: Pending[7]=1 and Stall=1.
  - After an ALU writeback with Rd=7: Stall=1 in the transfer cycle, Stall=0 in the following cycle.
REQ-035 SHALL cover writes to x0:
  - Stimulus: MemValid with Rd=0, Data=0xFFFFFFFF.
  - Required response: MemReady=1, WE stays 0, Pending unchanged.
  - Stimulus: IssueValid with Rs1=0, Rs2=0, Rd=0.
  - Required response: Stall=0.
REQ-036 SHALL cover simultaneous set and clear:
  - Stimulus: issue Rd=9 in the same cycle as a writeback transfer with Rd=9.
  - Required response: Pending[9]=1 afterwards.
REQ-037 SHALL cover sustained contention:
  - Stimulus: both requesters valid for 6 cycles.
  - Required response: grants alternate ALU, Mem, ALU, Mem, ALU, Mem.
  - No Ready without its Valid.
REQ-038 SHALL cover reset mid-operation:
  - Stimulus: Rst_n low in the cycle after a transfer.
  - Required response: WE=0 with no write, Pending=0, then the ALU wins the next conflict.
